// File: rtl/seq_multiplier.sv
// Sequential 32x32 shift-add multiplier: AND gate, 33-bit add, 64-bit shift register, 32 busy cycles.
// Optional two's-complement mode is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic [63:0] result,
   output logic        ready
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   logic [31:0] mcand;
   logic [5:0]  count;
   logic [31:0] and_out;
   logic [32:0] add_out;
   logic [63:0] shifted;
   logic [31:0] load_a;
   logic [31:0] load_b;

`ifdef SEQ_MUL_SIGNED_EN
   logic        sign;
   logic [63:0] final_val;

   // Magnitudes only; -2^31 maps to unsigned 2^31, which fits in 32 bits.
   always_comb begin
      load_a    = multiplicand[31] ? (~multiplicand + 32'd1) : multiplicand;
      load_b    = multiplier[31]   ? (~multiplier + 32'd1)   : multiplier;
      final_val = sign ? (~shifted + 64'd1) : shifted;
   end
`else
   always_comb begin
      load_a = multiplicand;
      load_b = multiplier;
   end
`endif

   always_comb begin
      and_out = mcand & {32{result[0]}};
      add_out = {1'b0, result[63:32]} + {1'b0, and_out};
      shifted = {add_out, result[31:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         result <= 64'd0;
         mcand  <= 32'd0;
         count  <= 6'd0;
`ifdef SEQ_MUL_SIGNED_EN
         sign   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  result <= {32'd0, load_b};
                  mcand  <= load_a;
                  count  <= 6'd32;
                  state  <= BUSY;
                  ready  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
                  sign   <= multiplicand[31] ^ multiplier[31];
`endif
               end
            end
            BUSY: begin
               count <= count - 6'd1;
               if (count == 6'd1) begin
`ifdef SEQ_MUL_SIGNED_EN
                  result <= final_val;
`else
                  result <= shifted;
`endif
                  state  <= IDLE;
                  ready  <= 1'b1;
               end else begin
                  result <= shifted;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: latency, products, ignored start, mid-operation reset.
// Expected values follow SEQ_MUL_SIGNED_EN when the bench is built with that macro.
module tb_seq_multiplier;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic [63:0] result;
   logic        ready;

   int total;
   int bad;

   seq_multiplier dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .multiplicand(multiplicand),
      .multiplier(multiplier),
      .result(result),
      .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // mode 0: plain run; 1: stray start at busy cycle 10; 2: reset at busy cycle 15
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int mode);
      int wait_cnt;
      wait_cnt = 0;
      while (ready !== 1'b1 && wait_cnt < 100) begin
         @(posedge clk);
         #1;
         wait_cnt++;
      end
      check({tag, "_idle_before"}, {63'd0, ready}, 64'd1);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      multiplicand = $urandom_range(32'hFFFF, 0);
      multiplier   = $urandom_range(32'hFFFF, 0);
      check({tag, "_busy_0"}, {63'd0, ready}, 64'd0);
      for (int i = 1; i < 32; i++) begin
         if (mode == 1 && i == 10) begin
            multiplicand = 32'hDEAD_0001;
            multiplier   = 32'h0BAD_F00D;
            start        = 1'b1;
         end
         if (mode == 2 && i == 15) rst = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (mode == 2 && i == 15) begin
            rst = 1'b0;
            check({tag, "_rst_result"}, result, 64'd0);
            check({tag, "_rst_ready"}, {63'd0, ready}, 64'd1);
            return;
         end
         if (i == 31) check({tag, "_busy_31"}, {63'd0, ready}, 64'd0);
         else if (ready !== 1'b0) check({tag, "_busy_mid"}, {63'd0, ready}, 64'd0);
      end
      @(posedge clk);
      #1;
      check({tag, "_ready"}, {63'd0, ready}, 64'd1);
      check({tag, "_product"}, result, exp);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      start        = 1'b1;
      multiplicand = 32'd7;
      multiplier   = 32'd9;
      @(posedge clk);
      #1;
      check("reset_result", result, 64'd0);
      check("reset_ready", {63'd0, ready}, 64'd1);
      @(posedge clk);
      #1;
      check("reset_priority", result, 64'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;

      run_mul("one_by_two", 32'd1, 32'd2, 64'h0000_0000_0000_0002, 0);
`ifdef SEQ_MUL_SIGNED_EN
      run_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
      run_mul("min_by_two", 32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000, 0);
      run_mul("neg1_by_2", 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_mul("neg3_by_neg5", 32'hFFFF_FFFD, 32'hFFFF_FFFB, 64'd15, 0);
`else
      run_mul("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
      run_mul("min_by_two", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0);
`endif
      run_mul("b_zero", 32'h1234_5678, 32'd0, 64'd0, 0);
      run_mul("a_zero", 32'd0, 32'hDEAD_BEEF, 64'd0, 0);
      run_mul("hold_src", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 0);

      multiplicand = 32'h5555_5555;
      multiplier   = 32'hAAAA_AAAA;
      repeat (5) @(posedge clk);
      #1;
      check("idle_hold_result", result, 64'h0000_0000_FFFE_0001);
      check("idle_hold_ready", {63'd0, ready}, 64'd1);

      run_mul("stray_start", 32'h0001_0003, 32'h0000_0100, 64'h0000_0000_0100_0300, 1);
      run_mul("mid_reset", 32'h0000_1234, 32'h0000_5678, 64'd0, 2);
      run_mul("after_reset", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 0);
      run_mul("five_by_seven", 32'd5, 32'd7, 64'd35, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Gate-style sequential 32×32 shift-add multiplier with integrated control unit, producing a 64-bit product over 32 iteration cycles. It is the multicycle multiply unit behind the ALU/execution stage. The caller presents operands with a one-cycle start pulse and waits for `ready`. The datapath is a 32-bit AND gating stage, a 32-bit adder with carry-out and a 64-bit product/shift register.

## Interface
Parameters:
- none. Widths are fixed: 32-bit operands, 64-bit product.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset. Synchronous and active-high.
- `start`  input  1  begin a multiply. Sampled only while `ready`=1.
- `multiplicand`  input  32  operand A. Captured on an accepted start.
- `multiplier`  input  32  operand B. Captured on an accepted start.
- `result`  output  64  product register. Final value is valid while `ready`=1 after a completed operation.
- `ready`  output  1  high when idle. Low while an operation is in progress.

## Operation
- States: IDLE (`ready`=1) and BUSY (`ready`=0). A 6-bit down-counter `count` tracks the remaining iterations.
- IDLE with `start`=1 (load):
  - `result` <= {32'b0, multiplier}
  - the multiplicand register <= `multiplicand`
  - `count` <= 32, and the state moves to BUSY.
- IDLE with `start`=0: hold all state. `result` keeps the last product.
- BUSY, each cycle:
  - Gate: `and_out` = multiplicand & {32{result[0]}}.
  - Add: {carry, sum} = result[63:32] + `and_out`, computed as a 33-bit unsigned sum.
  - Shift: `result` <= {carry, sum, result[31:1]}, a logical right shift by 1 that brings in the adder carry.
  - Decrement: `count` <= `count` − 1. When `count` reaches 0, return to IDLE.
- After 32 iterations, `result` = multiplicand × multiplier, unsigned, exact across all 64 bits. No overflow is possible.
- `start` asserted during BUSY is ignored. Operand inputs may change freely during BUSY without effect.

## Timing
- Reset values: `result` = 0, `ready` = 1, `count` = 0, state = IDLE. Reset takes priority over `start`.
- Latency: start accepted at edge N. `ready` falls after edge N and rises after edge N+32. The product is valid from that point.
- Back-to-back: `start` held high in the cycle where `ready` first returns to 1 is accepted at the next edge. The minimum issue interval is 33 cycles.
- Reset asserted mid-operation aborts the operation at the next edge. `result` clears to 0 and `ready` returns to 1.
- `result` shows partial products while BUSY. Consumers must qualify it with `ready`.

## Configuration
- `SEQ_MUL_SIGNED_EN` defined: operands are two's complement.
  - On load, the unit stores |multiplicand| and |multiplier| and latches sign = MSB(A) XOR MSB(B).
  - It runs the same 32 unsigned iterations.
  - On the final iteration, the written value is negated (64-bit two's complement) if sign=1.
  - Latency is unchanged at 32 busy cycles.
  - The magnitude of −2^31 is treated as an unsigned 2^31.
- Macro not defined: purely unsigned multiply, and no sign logic is present.

## Test plan
- Reset, then A=1, B=2, `start` pulse. Expect `ready`=0 for 32 cycles, then `ready`=1 and `result`=64'h0000_0000_0000_0002.
- A=32'hFFFF_FFFF, B=32'hFFFF_FFFF (unsigned build). Expect `result`=64'hFFFF_FFFE_0000_0001. This exercises the adder carry into the shift.
- A=32'h1234_5678, B=0, then A=0, B=32'hDEAD_BEEF. Expect `result`=0 for both. Also check `result` holds while idle with `start`=0.
- Start an operation, then pulse `start` again with different operands at cycle 10. Expect the second start ignored and the first product unchanged at completion.
- Assert `rst` at cycle 15 of an operation. Expect `result`=0 and `ready`=1 at the next edge, and a fresh start afterwards completes correctly.
- `SEQ_MUL_SIGNED_EN` build: A=32'hFFFF_FFFF (−1), B=2. Expect `result`=64'hFFFF_FFFF_FFFF_FFFE. For A=−3, B=−5, expect `result`=15.
